// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache that answers datapath fetches.
// Misses are served by a single-word read from the memory controller.
module icache_responder #(
    parameter int unsigned SETS = 16,
    parameter int unsigned PC_W = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            imemREN,
    input  logic [PC_W-1:0] imemaddr,
    output logic            ihit,
    output logic [PC_W-1:0] imemload,
    input  logic            inv,
    output logic            iREN,
    output logic [PC_W-1:0] iaddr,
    input  logic            iwait,
    input  logic [PC_W-1:0] iload
);

    localparam int unsigned IW = $clog2(SETS);
    localparam int unsigned TW = PC_W - IW - 2;

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t state;
    state_t state_nx;

    logic [SETS-1:0] valid;
    logic [TW-1:0]   tags [SETS];
    logic [PC_W-1:0] data [SETS];
    logic [PC_W-1:0] miss_addr;

    logic [IW-1:0]   req_idx;
    logic [TW-1:0]   req_tag;
    logic [IW-1:0]   miss_idx;
    logic [TW-1:0]   miss_tag;
    logic            hit;
    logic            fill;
    logic            latch_miss;
    logic            unused_byte_ofs;

    assign req_idx         = imemaddr[IW+1:2];
    assign req_tag         = imemaddr[PC_W-1:IW+2];
    assign miss_idx        = miss_addr[IW+1:2];
    assign miss_tag        = miss_addr[PC_W-1:IW+2];
    assign unused_byte_ofs = ^{imemaddr[1:0], miss_addr[1:0]};

    // inv suppresses the hit: the lines are being cleared this very edge.
    assign hit = imemREN & ~inv & valid[req_idx] & (tags[req_idx] == req_tag);

    // Next-state and combinational outputs; RST forces every output low.
    always_comb begin
        state_nx   = state;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        fill       = 1'b0;
        latch_miss = 1'b0;
        if (!RST) begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        ihit     = 1'b1;
                        imemload = data[req_idx];
                    end else if (imemREN) begin
                        latch_miss = 1'b1;
                        state_nx   = FETCH;
                    end
                end
                FETCH: begin
                    iREN  = 1'b1;
                    iaddr = miss_addr;
                    if (inv) begin
                        state_nx = IDLE;
                    end else if (!iwait) begin
                        fill     = 1'b1;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // State and valid bits; reset beats inv, inv beats a fill.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            valid <= '0;
        end else begin
            state <= state_nx;
            if (inv) begin
                valid <= '0;
            end else if (fill) begin
                valid[miss_idx] <= 1'b1;
            end
        end
    end

    // Tag/data arrays and the miss address carry no reset.
    always_ff @(posedge CLK) begin
        if (!RST && latch_miss) begin
            miss_addr <= {imemaddr[PC_W-1:2], 2'b00};
        end
        if (!RST && fill) begin
            tags[miss_idx] <= miss_tag;
            data[miss_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: directed test-plan steps followed by random
// traffic, all checked against a line-address model of the cache.
module tb_icache_responder;

    localparam int unsigned SETS = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        inv;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    icache_responder #(.SETS(SETS), .PC_W(32)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .inv      (inv),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Model: which word-aligned address each set holds, and an outstanding miss.
    bit          m_valid [SETS];
    logic [31:0] m_line  [SETS];
    logic [31:0] m_data  [SETS];
    bit          m_pending = 1'b0;
    logic [31:0] m_paddr = '0;

    logic        s_ihit;
    logic [31:0] s_load;
    logic        s_iren;
    logic [31:0] s_iaddr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs with the model, take the edge.
    task automatic cyc(input logic ren, input logic [31:0] addr, input logic inv_i,
                       input logic wait_i, input logic [31:0] load_i, input logic rst_i);
        int          idx;
        logic [31:0] wa;
        logic        e_hit;
        logic [31:0] e_load;
        logic        e_iren;
        logic [31:0] e_iaddr;
        imemREN  = ren;
        imemaddr = addr;
        inv      = inv_i;
        iwait    = wait_i;
        iload    = load_i;
        RST      = rst_i;
        idx = int'((addr / 4) % SETS);
        wa  = addr & ~32'h3;
        e_hit = 1'b0; e_load = '0; e_iren = 1'b0; e_iaddr = '0;
        if (!rst_i) begin
            if (m_pending) begin
                e_iren  = 1'b1;
                e_iaddr = m_paddr;
            end else if (ren && !inv_i && m_valid[idx] && m_line[idx] == wa) begin
                e_hit  = 1'b1;
                e_load = m_data[idx];
            end
        end
        #2;
        s_ihit = ihit; s_load = imemload; s_iren = iREN; s_iaddr = iaddr;
        check("ihit", 32'(s_ihit), 32'(e_hit));
        check("imemload", s_load, e_load);
        check("iREN", 32'(s_iren), 32'(e_iren));
        check("iaddr", s_iaddr, e_iaddr);
        @(posedge CLK);
        if (rst_i) begin
            m_pending = 1'b0;
            foreach (m_valid[i]) m_valid[i] = 1'b0;
        end else if (m_pending) begin
            if (inv_i) begin
                foreach (m_valid[i]) m_valid[i] = 1'b0;
                m_pending = 1'b0;
            end else if (!wait_i) begin
                idx = int'((m_paddr / 4) % SETS);
                m_valid[idx] = 1'b1;
                m_line[idx]  = m_paddr;
                m_data[idx]  = load_i;
                m_pending    = 1'b0;
            end
        end else begin
            if (inv_i) foreach (m_valid[i]) m_valid[i] = 1'b0;
            if (ren && !e_hit) begin
                m_pending = 1'b1;
                m_paddr   = wa;
            end
        end
        #1;
    endtask

    initial begin
        foreach (m_valid[i]) begin
            m_valid[i] = 1'b0;
            m_line[i]  = '0;
            m_data[i]  = '0;
        end
        RST = 1'b1; imemREN = 1'b0; imemaddr = '0; inv = 1'b0; iwait = 1'b1; iload = '0;
        @(posedge CLK); #1;
        cyc(1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
        check("rst_ihit", 32'(s_ihit), 32'h0);
        check("rst_iren", 32'(s_iren), 32'h0);

        // Cold miss: two wait cycles then data.
        cyc(1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        check("cold_c0_ihit", 32'(s_ihit), 32'h0);
        cyc(1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        check("cold_c1_iren", 32'(s_iren), 32'h1);
        cyc(1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        check("cold_c2_iren", 32'(s_iren), 32'h1);
        cyc(1'b1, 32'h0, 1'b0, 1'b0, 32'h3C010001, 1'b0);
        check("cold_c3_iaddr", s_iaddr, 32'h0);
        cyc(1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        check("cold_c4_ihit", 32'(s_ihit), 32'h1);
        check("cold_c4_load", s_load, 32'h3C010001);

        // Warm hit with byte offset bits set.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'h2, 1'b0, 1'b1, 32'h0, 1'b0);
            check("warm_ihit", 32'(s_ihit), 32'h1);
            check("warm_iren", 32'(s_iren), 32'h0);
        end

        // Conflict eviction: 0x40 shares set 0 with 0x0.
        cyc(1'b1, 32'h40, 1'b0, 1'b1, 32'h0, 1'b0);
        check("conf40_miss", 32'(s_ihit), 32'h0);
        cyc(1'b1, 32'h40, 1'b0, 1'b0, 32'h11112222, 1'b0);
        check("conf40_iaddr", s_iaddr, 32'h40);
        cyc(1'b1, 32'h40, 1'b0, 1'b1, 32'h0, 1'b0);
        check("conf40_hit", s_load, 32'h11112222);
        cyc(1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        check("conf0_miss", 32'(s_ihit), 32'h0);
        cyc(1'b1, 32'h0, 1'b0, 1'b0, 32'h3C010001, 1'b0);
        check("conf0_iren", 32'(s_iren), 32'h1);
        check("conf0_iaddr", s_iaddr, 32'h0);
        cyc(1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);

        // Idle, no request.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 32'h100, 1'b0, 1'b1, 32'h0, 1'b0);
            check("idle_ihit", 32'(s_ihit), 32'h0);
            check("idle_iren", 32'(s_iren), 32'h0);
        end

        // inv mid-FETCH discards the fill even with iwait low.
        cyc(1'b1, 32'h8, 1'b0, 1'b1, 32'h0, 1'b0);
        cyc(1'b1, 32'h8, 1'b0, 1'b1, 32'h0, 1'b0);
        cyc(1'b1, 32'h8, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
        check("inv_fetch_iren", 32'(s_iren), 32'h1);
        cyc(1'b1, 32'h8, 1'b0, 1'b1, 32'h0, 1'b0);
        check("inv_after_ihit", 32'(s_ihit), 32'h0);
        check("inv_after_idle", 32'(s_iren), 32'h0);
        cyc(1'b1, 32'h8, 1'b0, 1'b0, 32'h0000AAAA, 1'b0);
        cyc(1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        check("inv_0_miss", 32'(s_ihit), 32'h0);
        cyc(1'b1, 32'h0, 1'b0, 1'b0, 32'h3C010001, 1'b0);

        // RST mid-FETCH abandons the request.
        cyc(1'b1, 32'h10, 1'b0, 1'b1, 32'h0, 1'b0);
        cyc(1'b1, 32'h10, 1'b0, 1'b1, 32'h0, 1'b0);
        cyc(1'b1, 32'h10, 1'b0, 1'b0, 32'h55555555, 1'b1);
        check("rstf_iren", 32'(s_iren), 32'h0);
        check("rstf_ihit", 32'(s_ihit), 32'h0);
        cyc(1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        check("rstf_0_miss", 32'(s_ihit), 32'h0);
        check("rstf_idle", 32'(s_iren), 32'h0);
        cyc(1'b1, 32'h0, 1'b0, 1'b0, 32'h3C010001, 1'b0);

        // Random traffic over a few tags so hits, conflicts and fills all occur.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
                | 32'($urandom_range(0, 3));
            cyc(1'($urandom_range(0, 9) != 0), a, 1'($urandom_range(0, 39) == 0),
                1'($urandom_range(0, 2) == 0), $urandom, 1'($urandom_range(0, 59) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
